pulse_period_checker: RTL and testbench

//  Receive-side monitor for the periodic single-cycle strobe from the delay/tick generator.

---
 rtl/pulse_period_checker.sv | 112 +++++++++++
 tb/tb_pulse_period_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_checker.sv
// Watchdog for a periodic single-cycle strobe: measures strobe spacing, locks after
// LOCK_CNT good periods, then flags early/late strobes and holds a sticky fault.
module pulse_period_checker #(
    parameter int N        = 7500,
    parameter int CBITS    = 13,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clr_fault,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic             fault,
    output logic [CBITS-1:0] period,
    output logic [15:0]      pulse_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [CBITS-1:0] GAP_MAX  = '1;
    localparam logic [CBITS-1:0] GAP_LO   = CBITS'(N - TOL);
    localparam logic [CBITS-1:0] GAP_HI   = CBITS'(N + TOL);
    localparam logic [CBITS-1:0] GAP_LATE = CBITS'(N + TOL + 1);
    localparam logic [3:0]       GOOD_LAST = 4'(LOCK_CNT - 1);

    state_t           state;
    state_t           state_n;
    logic [CBITS-1:0] gap;
    logic [CBITS-1:0] gap_inc;
    logic [3:0]       good;
    logic             gap_ok;
    logic             early_n;
    logic             late_n;
    logic             strobe;

    // gap+1 saturating; doubles as the capped period value
    assign gap_inc   = (gap == GAP_MAX) ? gap : gap + CBITS'(1);
    assign gap_ok    = (gap >= GAP_LO) && (gap <= GAP_HI);
    assign strobe    = pulse_in && (state != FAULT);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        early_n = 1'b0;
        late_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pulse_in) state_n = ACQUIRE;
            end
            ACQUIRE: begin
                if (pulse_in) begin
                    if (gap_ok && (good == GOOD_LAST)) state_n = LOCKED;
                end else if (gap == GAP_LATE) begin
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                // a strobe landing exactly on the late threshold still counts as late
                if (gap == GAP_LATE) begin
                    late_n  = 1'b1;
                    state_n = FAULT;
                end else if (pulse_in && (gap < GAP_LO)) begin
                    early_n = 1'b1;
                    state_n = FAULT;
                end
            end
            FAULT: begin
                if (clr_fault) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap       <= '0;
            good      <= '0;
            locked    <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            fault     <= 1'b0;
            period    <= '0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_n;
            locked    <= (state_n == LOCKED);
            fault     <= (state_n == FAULT);
            err_early <= early_n;
            err_late  <= late_n;

            if (strobe) gap <= '0;
            else        gap <= gap_inc;

            if (strobe && (pulse_cnt != 16'hFFFF)) pulse_cnt <= pulse_cnt + 16'd1;

            if (pulse_in && ((state == ACQUIRE) || (state == LOCKED))) period <= gap_inc;

            if (pulse_in && (state == IDLE))         good <= '0;
            else if (pulse_in && (state == ACQUIRE)) good <= gap_ok ? good + 4'd1 : 4'd0;
        end
    end

endmodule

// File: tb/tb_pulse_period_checker.sv
// Randomized + directed bench for pulse_period_checker with a timestamp-based reference
// model feeding an expected-output queue that a negedge monitor drains.
module tb_pulse_period_checker;

    localparam int N        = 10;
    localparam int CBITS    = 4;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int GMAX     = (1 << CBITS) - 1;
    localparam int VW       = 2 + 4 + CBITS + 16;

    localparam int S_IDLE = 0;
    localparam int S_ACQ  = 1;
    localparam int S_LOCK = 2;
    localparam int S_FLT  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pulse_in = 1'b0;
    logic             clr_fault = 1'b0;
    logic             locked, err_early, err_late, fault;
    logic [CBITS-1:0] period;
    logic [15:0]      pulse_cnt;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_q[$];

    // reference model state
    longint edge_k    = 0;
    longint zero_edge = 0;
    int     m_st      = S_IDLE;
    int     m_good    = 0;
    int     m_per     = 0;
    int     m_cnt     = 0;

    pulse_period_checker #(
        .N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .clr_fault (clr_fault),
        .locked    (locked),
        .err_early (err_early),
        .err_late  (err_late),
        .fault     (fault),
        .period    (period),
        .pulse_cnt (pulse_cnt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // gap is the number of edges since the last clearing edge, minus one, saturated
    task automatic model_edge(input logic p, input logic c, input logic r);
        longint g;
        logic   e_e, e_l;
        edge_k++;
        e_e = 1'b0;
        e_l = 1'b0;
        if (r) begin
            m_st = S_IDLE; zero_edge = edge_k; m_good = 0; m_per = 0; m_cnt = 0;
        end else begin
            g = edge_k - zero_edge - 1;
            if (g > GMAX) g = GMAX;
            if (p && m_st != S_FLT) begin
                zero_edge = edge_k;
                if (m_cnt < 65535) m_cnt++;
            end
            case (m_st)
                S_IDLE: if (p) begin m_st = S_ACQ; m_good = 0; end
                S_ACQ: begin
                    if (p) begin
                        m_per = (g + 1 > GMAX) ? GMAX : int'(g + 1);
                        if (g >= N - TOL && g <= N + TOL) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_st = S_LOCK;
                        end else begin
                            m_good = 0;
                        end
                    end else if (g == N + TOL + 1) begin
                        m_st = S_IDLE;
                    end
                end
                S_LOCK: begin
                    if (p) m_per = (g + 1 > GMAX) ? GMAX : int'(g + 1);
                    if (g == N + TOL + 1) begin
                        e_l = 1'b1; m_st = S_FLT;
                    end else if (p && g < N - TOL) begin
                        e_e = 1'b1; m_st = S_FLT;
                    end
                end
                default: if (c) m_st = S_IDLE;
            endcase
        end
        exp_q.push_back({2'(m_st), (m_st == S_LOCK), e_e, e_l, (m_st == S_FLT),
                         CBITS'(m_per), 16'(m_cnt)});
    endtask

    // one clock: drive inputs after negedge, model the posedge, settle past it
    task automatic step(input logic p, input logic c, input logic r);
        @(negedge clk);
        #1;
        pulse_in  = p;
        clr_fault = c;
        rst       = r;
        @(posedge clk);
        model_edge(p, c, r);
        #1;
    endtask

    task automatic strobe_after(input int n, input bit rnd_clr);
        for (int i = 0; i < n - 1; i++) step(1'b0, rnd_clr && ($urandom_range(0, 7) == 0), 1'b0);
        step(1'b1, rnd_clr && ($urandom_range(0, 7) == 0), 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // monitor: outputs update every cycle, so one expectation is consumed per negedge
    always @(negedge clk) begin
        logic [VW-1:0] want;
        logic [VW-1:0] got;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {state_dbg, locked, err_early, err_late, fault, period, pulse_cnt};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs: got %h expected %h at %0t", got, want, $time);
            end
            if (err_early && err_late) begin
                checks++;
                errors++;
                $display("FAIL err_exclusive: got both err_early and err_late at %0t", $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("reset_outputs", {locked, err_early, err_late, fault, period, pulse_cnt, state_dbg}, 0);

        // 1: lock on steady 11-cycle strobes
        step(1'b1, 1'b0, 1'b0);
        chk("t1_acquire", state_dbg, S_ACQ);
        strobe_after(11, 0);
        strobe_after(11, 0);
        chk("t1_not_yet_locked", locked, 0);
        strobe_after(11, 0);
        chk("t1_locked", locked, 1);
        chk("t1_period", period, 11);
        strobe_after(11, 0);
        strobe_after(11, 0);
        chk("t1_no_err", {err_early, err_late}, 0);
        chk("t1_cnt", pulse_cnt, 6);

        // 2: early strobe
        strobe_after(8, 0);
        chk("t2_err_early", err_early, 1);
        chk("t2_err_late", err_late, 0);
        chk("t2_fault", fault, 1);
        chk("t2_unlocked", locked, 0);
        chk("t2_period", period, 8);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_early_pulse", err_early, 0);
        chk("t2_fault_sticky", fault, 1);

        // 4: clear wins over simultaneous strobe, then relock
        step(1'b1, 1'b1, 1'b0);
        chk("t4_idle", state_dbg, S_IDLE);
        chk("t4_fault_clr", fault, 0);
        strobe_after(11, 0);
        chk("t4_acquire", state_dbg, S_ACQ);
        strobe_after(11, 0);
        strobe_after(11, 0);
        chk("t4_not_locked", locked, 0);
        strobe_after(11, 0);
        chk("t4_relocked", locked, 1);

        // 3: strobes stop
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        chk("t3_no_late_yet", {err_late, locked}, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_err_late", err_late, 1);
        chk("t3_no_early", err_early, 0);
        chk("t3_fault", fault, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_late_pulse", err_late, 0);
        for (int i = 0; i < 99; i++) step($urandom_range(0, 3) == 0, 1'b0, 1'b0);
        chk("t3_fault_held", fault, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("t3_cleared", state_dbg, S_IDLE);

        // 5: bad gap during acquire restarts the good count
        step(1'b1, 1'b0, 1'b0);
        strobe_after(11, 0);
        strobe_after(11, 0);
        strobe_after(13, 0);
        chk("t5_still_acq", state_dbg, S_ACQ);
        chk("t5_no_err", {err_early, err_late}, 0);
        chk("t5_period", period, 13);
        strobe_after(11, 0);
        strobe_after(11, 0);
        chk("t5_not_locked", locked, 0);
        strobe_after(11, 0);
        chk("t5_locked", locked, 1);

        // 6: reset mid-lock
        step(1'b0, 1'b0, 1'b1);
        chk("t6_reset", {locked, err_early, err_late, fault, period, pulse_cnt, state_dbg}, 0);

        // random phase
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, 1'b0, 1'b1);
            end else if ($urandom_range(0, 19) == 0) begin
                strobe_after($urandom_range(14, 30), 1);
            end else begin
                strobe_after($urandom_range(0, 3) == 0 ? $urandom_range(6, 14) : $urandom_range(10, 12), 1);
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
